// File: rtl/fetch_sequencer_pkg.sv
// Shared state encoding, PCSrc selector values and the reset PC for the fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StHold  = 2'b01,
        StError = 2'b10
    } state_e;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection for a retiring instruction, with reserved-selector
// and alignment flags.
module fetch_sequencer_next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr_pc,
    input  logic [1:0]      i_pcsrc,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic [XLEN-1:0] i_alu_result,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_bad_src,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_seq_pc;

    assign w_seq_pc = i_instr_pc + XLEN'(4);

    always_comb begin
        o_bad_src = 1'b0;
        o_next_pc = w_seq_pc;
        case (i_pcsrc)
            PCSRC_SEQ:  o_next_pc = w_seq_pc;
            PCSRC_BR:   o_next_pc = i_instr_pc + i_imm_ext;
            PCSRC_JALR: o_next_pc = i_alu_result & ~XLEN'(1);
            default: begin
                // Reserved selector still yields a sane sequential PC for debug.
                o_next_pc = w_seq_pc;
                o_bad_src = 1'b1;
            end
        endcase
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction-fetch handshake FSM (FETCH -> HOLD -> FETCH).
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    output logic            fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_fetch_err;
    logic [3:0]      r_wait_cnt;

    logic [XLEN-1:0] w_next_pc;
    logic            w_bad_src;
    logic            w_misaligned;

    fetch_sequencer_next_pc_calc #(
        .XLEN (XLEN)
    ) u_next_pc_calc (
        .i_instr_pc   (r_instr_pc),
        .i_pcsrc      (PCSrc),
        .i_imm_ext    (ImmExt),
        .i_alu_result (ALUResult),
        .o_next_pc    (w_next_pc),
        .o_bad_src    (w_bad_src),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StFetch;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            case (r_state)
                StFetch: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_wait_cnt    <= '0;
                        r_instr_valid <= 1'b1;
                        r_state       <= StHold;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                        // The MAX_WAIT-th consecutive miss is fatal.
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= StError;
                        end
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        if (w_bad_src || w_misaligned) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= StError;
                        end else begin
                            r_state <= StFetch;
                        end
                    end
                end
                StError: r_state <= StError;
                default: begin
                    r_instr_valid <= 1'b0;
                    r_fetch_err   <= 1'b1;
                    r_state       <= StError;
                end
            endcase
        end
    end

    // Request is suppressed during the reset cycle itself.
    assign imem_req    = rst_n && (r_state == StFetch);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retired_cnt;
    logic [31:0] r_redirect_cnt;
    logic        w_retire;

    assign w_retire = r_instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt    <= '0;
            r_retired_cnt  <= '0;
            r_redirect_cnt <= '0;
        end else if (r_state != StError) begin
            if (r_cycle_cnt != '1) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_retire && (r_retired_cnt != '1)) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_retire && (PCSrc != PCSRC_SEQ) && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt    = r_cycle_cnt;
    assign retired_cnt  = r_retired_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
    logic [31:0] redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .ALUResult   (ALUResult),
        .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .retired_cnt  (retired_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    // Reference model: one instruction in flight, a sticky error, and a miss counter.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_err, m_rst_lvl;
    int          m_misses;
    logic [31:0] m_cyc, m_ret, m_redir;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] target(input logic [1:0] src, input logic [31:0] ipc,
                                           input logic [31:0] imm, input logic [31:0] alu);
        if (src == 2'd1) return ipc + imm;
        if (src == 2'd2) return alu - (alu % 2);
        return ipc + 32'd4;
    endfunction

    task automatic model_update(input bit rst, input bit ack, input logic [31:0] rdata,
                                input bit rdy, input logic [1:0] src,
                                input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] t;
        if (!rst) begin
            m_pc = RST_PC; m_instr = '0; m_ipc = '0;
            m_valid = 0; m_err = 0; m_misses = 0;
            m_cyc = '0; m_ret = '0; m_redir = '0;
        end else if (!m_err) begin
            m_cyc = m_cyc + 1;
            if (!m_valid) begin
                if (ack) begin
                    m_instr = rdata; m_ipc = m_pc; m_valid = 1; m_misses = 0;
                end else begin
                    m_misses++;
                    if (m_misses == MAX_WAIT) m_err = 1;
                end
            end else if (rdy) begin
                m_ret = m_ret + 1;
                if (src != 2'd0) m_redir = m_redir + 1;
                t = target(src, m_ipc, imm, alu);
                m_pc = t;
                m_valid = 0;
                if (src == 2'd3 || (t % 4) != 0) m_err = 1;
            end
        end
    endtask

    task automatic check_all();
        bit exp_req;
        exp_req = m_rst_lvl && !m_valid && !m_err;
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", instr_valid, m_valid);
        check("fetch_err", fetch_err, m_err);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("retired_cnt", retired_cnt, m_ret);
        check("redirect_cnt", redirect_cnt, m_redir);
`endif
    endtask

    // Drive one cycle of inputs after a negedge, step the model at posedge, check at negedge.
    task automatic cyc(input bit rst, input bit ack, input logic [31:0] rdata, input bit rdy,
                       input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        rst_n = rst; imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
        PCSrc = src; ImmExt = imm; ALUResult = alu;
        m_rst_lvl = rst;
        @(posedge clk);
        model_update(rst, ack, rdata, rdy, src, imm, alu);
        @(negedge clk);
        check_all();
    endtask

    // Fetch one word (ack on first FETCH cycle) then retire it with the given redirect.
    task automatic fetch_retire(input logic [31:0] word, input logic [1:0] src,
                                input logic [31:0] imm, input logic [31:0] alu);
        cyc(1, 1, word, 0, 2'd0, 0, 0);
        cyc(1, 0, 0, 1, src, imm, alu);
    endtask

    initial begin
        logic [31:0] held_instr, held_pc;
        m_rst_lvl = 0;
        rst_n = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        PCSrc = 0; ImmExt = 0; ALUResult = 0;
        @(negedge clk);

        // Reset, with an ack in the reset cycle that must be discarded.
        cyc(0, 0, 0, 0, 2'd0, 0, 0);
        cyc(0, 1, 32'hDEAD_BEEF, 1, 2'd0, 0, 0);
        check("rst_req", imem_req, 0);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);

        // First fetch at RESET_PC, sequential retire.
        cyc(1, 1, 32'h0050_0093, 0, 2'd0, 0, 0);
        check("tp1_valid", instr_valid, 1);
        check("tp1_instr", instr, 32'h0050_0093);
        check("tp1_pc", instr_pc, 32'h0);
        cyc(1, 0, 0, 1, 2'd0, 0, 0);
        check("tp1_next", imem_addr, 32'h4);

        // Reach 0x10, then branch back by -8.
        fetch_retire(32'h1111_1111, 2'd1, 32'h0000_000C, 0);
        check("br_to_10", imem_addr, 32'h10);
        fetch_retire(32'h2222_2222, 2'd1, 32'hFFFF_FFF8, 0);
        check("br_neg", imem_addr, 32'h08);

        // From 0x10 with +0x20, then jalr with odd target.
        cyc(0, 0, 0, 0, 2'd0, 0, 0);
        fetch_retire(32'h3333_3333, 2'd1, 32'h10, 0);
        fetch_retire(32'h4444_4444, 2'd1, 32'h20, 0);
        check("br_pos", imem_addr, 32'h30);
        fetch_retire(32'h5555_5555, 2'd2, 0, 32'h0000_0105);
        check("jalr", imem_addr, 32'h104);

        // Misaligned branch target is fatal and sticky.
        fetch_retire(32'h6666_6666, 2'd1, 32'h2, 0);
        check("mis_err", fetch_err, 1);
        check("mis_req", imem_req, 0);
        check("mis_valid", instr_valid, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h7777_7777, 1, 2'd0, 0, 0);
        check("mis_sticky", fetch_err, 1);
        cyc(0, 0, 0, 0, 2'd0, 0, 0);
        check("mis_rst_addr", imem_addr, RST_PC);
        check("mis_rst_err", fetch_err, 0);

        // Fifteen missed acks time out.
        for (int i = 0; i < MAX_WAIT; i++) cyc(1, 0, 0, 0, 2'd0, 0, 0);
        check("timeout_err", fetch_err, 1);

        // Ack on the fourteenth FETCH cycle is still in time.
        cyc(0, 0, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 2'd0, 0, 0);
        cyc(1, 1, 32'hABCD_0001, 0, 2'd0, 0, 0);
        check("late_ack_valid", instr_valid, 1);
        check("late_ack_err", fetch_err, 0);

        // Stalled HOLD: contents stable, acks ignored, no request.
        held_instr = instr; held_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 32'hFFFF_0000, 0, 2'd0, 0, 0);
            check("stall_instr", instr, held_instr);
            check("stall_pc", instr_pc, held_pc);
            check("stall_req", imem_req, 0);
        end
        cyc(0, 0, 0, 1, 2'd0, 0, 0);
        check("hold_rst_valid", instr_valid, 0);

        // Reserved PCSrc.
        fetch_retire(32'h1234_5678, 2'd3, 0, 0);
        check("bad_src_err", fetch_err, 1);
        cyc(0, 0, 0, 0, 2'd0, 0, 0);

        // Random traffic with occasional resets (always after an error, eventually).
        for (int i = 0; i < 4000; i++) begin
            bit          r, a, rd;
            logic [1:0]  s;
            logic [31:0] imm;
            int          v;
            r  = !(($urandom_range(0, 199) == 0) || (m_err && $urandom_range(0, 3) == 0));
            a  = $urandom_range(0, 2) != 0;
            rd = $urandom_range(0, 1) != 0;
            v  = $urandom_range(0, 19);
            s  = (v < 8) ? 2'd0 : (v < 14) ? 2'd1 : (v < 19) ? 2'd2 : 2'd3;
            imm = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            cyc(r, a, $urandom, rd, s, imm, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
